// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with flush/bubble/hold control and stall statistics
module pipe_stage_reg #(
  parameter int                 DATA_W    = 160,
  parameter int                 STALL_W   = 6,
  parameter int                 STAGE_IDX = 2,
  parameter logic [DATA_W-1:0]  NOP_VAL   = '0,
  parameter int                 CNT_W     = 16,
  parameter int                 TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               clr_cnt,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic               hold_timeout
);
  if (STAGE_IDX < 0 || STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
    $error("pipe_stage_reg: STAGE_IDX out of range");
  end
  if (TIMEOUT < 1 || longint'(TIMEOUT) > (longint'(1) << CNT_W) - 1) begin : g_bad_timeout
    $error("pipe_stage_reg: TIMEOUT out of range");
  end
  logic own, down, bub, hld, unused_stall;
  assign own          = stall[STAGE_IDX];
  assign down         = stall[STAGE_IDX+1];
  assign bub          = !flush && own && !down;
  assign hld          = !flush && own && down;
  assign unused_stall = ^stall;
  assign hold_timeout = hold_cnt >= CNT_W'(TIMEOUT);
  // Stage is bypassed into hold only when we and our downstream both stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data   <= NOP_VAL;
      out_valid  <= 1'b0;
      bubble_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      out_data   <= (flush || bub) ? NOP_VAL : own ? out_data : in_valid ? in_data : NOP_VAL;
      out_valid  <= (flush || bub) ? 1'b0 : own ? out_valid : in_valid;
      hold_cnt   <= !hld ? '0 : (&hold_cnt) ? hold_cnt : hold_cnt + CNT_W'(1);
      bubble_cnt <= clr_cnt ? '0 : (bub && !(&bubble_cnt)) ? bubble_cnt + CNT_W'(1) : bubble_cnt;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
  localparam logic [7:0] NOP = 8'hEE;
  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic [2:0] bc;
    logic [2:0] hc;
    logic       to;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b0, flush = 1'b0, clr_cnt = 1'b0, in_valid = 1'b0;
  logic [5:0] stall = '0;
  logic [7:0] in_data = '0, out_data;
  logic       out_valid, hold_timeout;
  logic [2:0] bubble_cnt, hold_cnt;
  exp_t       q[$];
  int         n_chk = 0, n_fail = 0;

  pipe_stage_reg #(.DATA_W(8), .STALL_W(6), .STAGE_IDX(2), .NOP_VAL(NOP), .CNT_W(3), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .in_data(in_data), .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid),
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt), .hold_timeout(hold_timeout));

  always #5 clk = ~clk;

  function automatic exp_t E(input logic [7:0] d, input logic v, input logic [2:0] bc, hc, input logic to);
    return '{d: d, v: v, bc: bc, hc: hc, to: to};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk += 5;
      if (out_data !== e.d)     begin n_fail++; $display("FAIL out_data got %h exp %h @%0t", out_data, e.d, $time); end
      if (out_valid !== e.v)    begin n_fail++; $display("FAIL out_valid got %b exp %b @%0t", out_valid, e.v, $time); end
      if (bubble_cnt !== e.bc)  begin n_fail++; $display("FAIL bubble_cnt got %0d exp %0d @%0t", bubble_cnt, e.bc, $time); end
      if (hold_cnt !== e.hc)    begin n_fail++; $display("FAIL hold_cnt got %0d exp %0d @%0t", hold_cnt, e.hc, $time); end
      if (hold_timeout !== e.to) begin n_fail++; $display("FAIL hold_timeout got %b exp %b @%0t", hold_timeout, e.to, $time); end
    end
  end

  // Drive one cycle of stimulus just after a rising edge; optionally pulse reset before the next edge
  task automatic step(input logic [5:0] s, input logic f, c, v, input logic [7:0] d, input exp_t e, input bit prst = 1'b0);
    stall = s; flush = f; clr_cnt = c; in_valid = v; in_data = d;
    q.push_back(e);
    if (prst) begin
      #2 rst = 1'b0;
      #5 rst = 1'b1;
    end
    @(posedge clk);
  endtask

  localparam logic [5:0] ADV = 6'b000000, BUB = 6'b000111, HLD = 6'b001111, OTH = 6'b110000;

  initial begin
    repeat (2) @(posedge clk);
    step(HLD, 1, 1, 1, 8'h77, E(NOP, 0, 0, 0, 0));
    rst = 1'b1;
    step(ADV, 0, 0, 1, 8'hA5, E(8'hA5, 1, 0, 0, 0));
    step(ADV, 0, 0, 0, 8'h33, E(NOP, 0, 0, 0, 0));
    step(ADV, 0, 0, 1, 8'h11, E(8'h11, 1, 0, 0, 0));
    step(HLD, 0, 0, 1, 8'h77, E(8'h11, 1, 0, 1, 0));
    step(HLD, 0, 0, 1, 8'h78, E(8'h11, 1, 0, 2, 0));
    step(HLD, 0, 0, 1, 8'h79, E(8'h11, 1, 0, 3, 0));
    step(HLD, 0, 0, 1, 8'h7A, E(8'h11, 1, 0, 4, 1));
    step(HLD, 0, 0, 1, 8'h7B, E(8'h11, 1, 0, 5, 1));
    step(ADV, 0, 0, 1, 8'h22, E(8'h22, 1, 0, 0, 0));
    step(OTH, 0, 0, 1, 8'h44, E(8'h44, 1, 0, 0, 0));
    step(BUB, 0, 0, 1, 8'h45, E(NOP, 0, 1, 0, 0));
    step(BUB, 0, 0, 1, 8'h46, E(NOP, 0, 2, 0, 0));
    step(BUB, 0, 0, 1, 8'h47, E(NOP, 0, 3, 0, 0));
    step(BUB, 1, 0, 1, 8'h55, E(NOP, 0, 3, 0, 0));
    step(ADV, 0, 0, 1, 8'h66, E(8'h66, 1, 3, 0, 0));
    step(HLD, 0, 0, 1, 8'h67, E(8'h66, 1, 3, 1, 0));
    step(HLD, 1, 0, 1, 8'h68, E(NOP, 0, 3, 0, 0));
    step(BUB, 0, 1, 1, 8'h69, E(NOP, 0, 0, 0, 0));
    step(BUB, 0, 0, 1, 8'h6A, E(NOP, 0, 1, 0, 0));
    step(ADV, 0, 0, 1, 8'h12, E(8'h12, 1, 1, 0, 0));
    step(HLD, 0, 1, 1, 8'h13, E(8'h12, 1, 0, 1, 0));
    step(HLD, 0, 0, 1, 8'h14, E(8'h12, 1, 0, 2, 0));
    for (int i = 1; i <= 9; i++)
      step(BUB, 0, 0, 0, 8'h00, E(NOP, 0, 3'(i > 7 ? 7 : i), 0, 0));
    step(ADV, 0, 0, 1, 8'h99, E(8'h99, 1, 7, 0, 0));
    step(HLD, 0, 0, 1, 8'h9A, E(8'h99, 1, 7, 1, 0));
    step(HLD, 0, 0, 1, 8'h9B, E(8'h99, 1, 7, 2, 0));
    step(HLD, 0, 0, 1, 8'h9C, E(NOP, 0, 0, 0, 0), 1'b1);
    step(HLD, 0, 0, 1, 8'h9D, E(NOP, 0, 0, 1, 0));
    step(ADV, 0, 0, 1, 8'h5A, E(8'h5A, 1, 0, 0, 0));
    stall = '0; flush = 0; clr_cnt = 0; in_valid = 0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain queue has %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
